// File: rtl/vend_pkg.sv
// Shared types and helpers for the parametrised vending controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_CODE_A = 2'b01;
    localparam logic [1:0] COIN_CODE_B = 2'b10;
    localparam logic [1:0] COIN_CODE_C = 2'b11;

    // Value in units of a coin code, given the three configured denominations.
    function automatic int coin_value(input logic [1:0] code, input int val_a,
                                      input int val_b, input int val_c);
        case (code)
            COIN_CODE_A: coin_value = val_a;
            COIN_CODE_B: coin_value = val_b;
            COIN_CODE_C: coin_value = val_c;
            default:     coin_value = 0;
        endcase
    endfunction

    // Largest of three values, used to bound the credit range at elaboration.
    function automatic int max3(input int x, input int y, input int z);
        int m;
        m = x;
        if (y > m) m = y;
        if (z > m) m = z;
        max3 = m;
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// Down-counter emitting one registered change pulse per unit; shared by
// change-after-vend and refund. load and count in the same cycle loads the
// amount and issues the first pulse at once.
module change_dispenser #(
    parameter int CREDIT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [CREDIT_W-1:0] load_val,
    input  logic                count,
    output logic                change,
    output logic                done
);

    logic [CREDIT_W-1:0] cnt_q, cnt_d;
    logic                change_q, change_d;
    logic                done_q, done_d;

    // Next count, pulse and "nothing left" flag.
    always_comb begin
        cnt_d    = cnt_q;
        change_d = count;
        if (load) begin
            cnt_d = load_val - CREDIT_W'(count);
        end else if (count) begin
            cnt_d = cnt_q - 1'b1;
        end
        done_d = (cnt_d == '0);
    end

    // Counter and pulse registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q    <= '0;
            change_q <= 1'b0;
            done_q   <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            change_q <= change_d;
            done_q   <= done_d;
        end
    end

    assign change = change_q;
    assign done   = done_q;

endmodule

// File: rtl/vend_fsm_param.sv
// Vending controller: accumulates coin credit, vends at PRICE, pays change
// and refunds as serial unit pulses. All outputs come straight from flops.
module vend_fsm_param
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 4,
    parameter int PRICE    = 5,
    parameter int COIN_A   = 1,
    parameter int COIN_B   = 2,
    parameter int COIN_C   = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                product,
    output logic                change,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    localparam int MAX_COIN = max3(COIN_A, COIN_B, COIN_C);
    localparam logic [CREDIT_W:0] PRICE_W = (CREDIT_W+1)'(PRICE);

    // Credit can never exceed PRICE-1 plus one coin, so this keeps it in range.
    if (PRICE < 1 || COIN_A < 1 || COIN_B < 1 || COIN_C < 1 ||
        (PRICE - 1 + MAX_COIN) > (2**CREDIT_W - 1)) begin : g_param_err
        $error("vend_fsm_param: illegal parameter combination");
    end

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                product_q, product_d;
    logic                coin_reject_q, coin_reject_d;
    logic                busy_q, busy_d;

    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;
    logic                disp_load;
    logic [CREDIT_W-1:0] disp_load_val;
    logic                disp_count;
    logic                disp_done;

    assign coin_val = (CREDIT_W+1)'(coin_value(coin, COIN_A, COIN_B, COIN_C));
    assign sum      = {1'b0, credit_q} + coin_val;

    // Next-state and output decode; cancel beats a simultaneous coin.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        product_d     = 1'b0;
        coin_reject_d = 1'b0;
        disp_load     = 1'b0;
        disp_load_val = '0;
        disp_count    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cancel) begin
                    coin_reject_d = (coin != COIN_NONE);
                    if (credit_q != '0) begin
                        disp_load     = 1'b1;
                        disp_load_val = credit_q;
                        disp_count    = 1'b1;
                        credit_d      = '0;
                        state_d       = CHANGE;
                    end
                end else if (coin != COIN_NONE) begin
                    if (sum >= PRICE_W) begin
                        credit_d      = '0;
                        disp_load     = 1'b1;
                        disp_load_val = CREDIT_W'(sum - PRICE_W);
                        product_d     = 1'b1;
                        state_d       = VEND;
                    end else begin
                        credit_d = sum[CREDIT_W-1:0];
                    end
                end
            end
            VEND: begin
                coin_reject_d = (coin != COIN_NONE);
                if (!disp_done) begin
                    disp_count = 1'b1;
                    state_d    = CHANGE;
                end else begin
                    state_d = IDLE;
                end
            end
            CHANGE: begin
                coin_reject_d = (coin != COIN_NONE);
                if (disp_done) begin
                    state_d = IDLE;
                end else begin
                    disp_count = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            product_q     <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            product_q     <= product_d;
            coin_reject_q <= coin_reject_d;
            busy_q        <= busy_d;
        end
    end

    change_dispenser #(
        .CREDIT_W (CREDIT_W)
    ) u_change_dispenser (
        .clk      (clk),
        .reset    (reset),
        .load     (disp_load),
        .load_val (disp_load_val),
        .count    (disp_count),
        .change   (change),
        .done     (disp_done)
    );

    assign product     = product_q;
    assign coin_reject = coin_reject_q;
    assign credit      = credit_q;
    assign busy        = busy_q;

endmodule
